// File: rtl/call_dispatcher_if.sv
// call_dispatcher_if: links the hall-call dispatcher to the car prioritizer and the car controllers.
//   obj           target floor offered to the prioritizer
//   sel_a/b/c     prioritizer's one-hot car choice for obj (combinational from obj)
//   assign_a/b/c  grant to car A/B/C, held until that car acks or the grant times out
//   assign_floor  floor carried by the active grant
//   ack_a/b/c     car accepted its grant
// master: dispatcher side.  slave: prioritizer and car side.
interface call_dispatcher_if;
    logic [3:0] obj;
    logic       sel_a;
    logic       sel_b;
    logic       sel_c;
    logic       assign_a;
    logic       assign_b;
    logic       assign_c;
    logic [3:0] assign_floor;
    logic       ack_a;
    logic       ack_b;
    logic       ack_c;

    modport master (
        output obj,
        input  sel_a, sel_b, sel_c,
        output assign_a, assign_b, assign_c,
        output assign_floor,
        input  ack_a, ack_b, ack_c
    );

    modport slave (
        input  obj,
        output sel_a, sel_b, sel_c,
        input  assign_a, assign_b, assign_c,
        input  assign_floor,
        output ack_a, ack_b, ack_c
    );
endinterface

// File: rtl/call_dispatcher.sv
// call_dispatcher: hall-call dispatcher for the three-car elevator controller.
// Latches hall calls and scans them round-robin. Each pending floor is offered to the
// prioritizer, and the call is handed to the chosen car with an assign/ack handshake.
//   clk, rst_n  clock and asynchronous active-low reset
//   call_in     hall button levels; bit i requests floor i
//   pending     latched calls that have not been served
//   busy        high while a floor is being evaluated or granted
//   bus         prioritizer and car handshake (master side)
module call_dispatcher #(
    parameter int unsigned FLOORS  = 16,
    parameter int unsigned TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [FLOORS-1:0]    call_in,
    output logic [FLOORS-1:0]    pending,
    output logic                 busy,
    call_dispatcher_if.master    bus
);

    localparam int unsigned FLOOR_W = 4;
    localparam int unsigned TMR_W   = 8;
    localparam int unsigned CARS    = 3;
    localparam logic [FLOOR_W-1:0] LAST_FLOOR = FLOOR_W'(FLOORS - 1);
    localparam logic [TMR_W-1:0]   TMR_LAST   = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        GRANT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [FLOOR_W-1:0]   ptr_q, ptr_d;
    logic [FLOOR_W-1:0]   obj_q, obj_d;
    logic [CARS-1:0]      car_q, car_d;
    logic [TMR_W-1:0]     timer_q, timer_d;
    logic [FLOORS-1:0]    pending_q, pending_d;
    logic [CARS-1:0]      assign_q, assign_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 busy_q, busy_d;

    logic [15:0]          pend16;
    logic [15:0]          clr16;
    logic [FLOOR_W-1:0]   first_idx;
    logic [FLOOR_W-1:0]   scan_idx;
    logic                 found;
    logic [FLOOR_W-1:0]   nxt_ptr;
    logic [CARS-1:0]      sel_vec;
    logic [CARS-1:0]      ack_vec;
    logic [CARS-1:0]      sel_pick;

    // Pending calls zero-padded to 16 bits so a 4-bit floor index always selects in range.
    assign pend16  = 16'(pending_q);
    assign sel_vec = {bus.sel_c, bus.sel_b, bus.sel_a};
    assign ack_vec = {bus.ack_c, bus.ack_b, bus.ack_a};

    // Car A has priority over B, and B over C, when the prioritizer names several cars.
    assign sel_pick = bus.sel_a ? 3'b001 : (bus.sel_b ? 3'b010 : 3'b100);

    // The round-robin pointer moves to the floor after the one just handled, wrapping at the top.
    assign nxt_ptr = (obj_q == LAST_FLOOR) ? '0 : obj_q + FLOOR_W'(1);

    // Finds the first pending floor at or after ptr, wrapping past the top floor.
    always_comb begin
        first_idx = ptr_q;
        scan_idx  = '0;
        found     = 1'b0;
        for (int unsigned i = 0; i < FLOORS; i++) begin
            scan_idx = FLOOR_W'((32'(ptr_q) + i) % FLOORS);
            if (!found && pend16[scan_idx]) begin
                found     = 1'b1;
                first_idx = scan_idx;
            end
        end
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        obj_d    = obj_q;
        car_d    = car_q;
        timer_d  = timer_q;
        assign_d = assign_q;
        floor_d  = floor_q;
        clr16    = '0;

        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    obj_d   = first_idx;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (|sel_vec) begin
                    car_d    = sel_pick;
                    assign_d = sel_pick;
                    floor_d  = obj_q;
                    timer_d  = '0;
                    state_d  = GRANT;
                end else begin
                    // No car can take this floor now; it stays pending for a later pass.
                    ptr_d   = nxt_ptr;
                    state_d = IDLE;
                end
            end
            GRANT: begin
                if (|(car_q & ack_vec)) begin
                    clr16    = 16'd1 << obj_q;
                    assign_d = '0;
                    ptr_d    = nxt_ptr;
                    state_d  = IDLE;
                end else if (timer_q == TMR_LAST) begin
                    assign_d = '0;
                    ptr_d    = nxt_ptr;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                assign_d = '0;
                state_d  = IDLE;
            end
        endcase

        // A press on the floor being acked in this same cycle is absorbed by the clear.
        pending_d = (pending_q | call_in) & ~FLOORS'(clr16);
        busy_d    = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            obj_q     <= '0;
            car_q     <= '0;
            timer_q   <= '0;
            pending_q <= '0;
            assign_q  <= '0;
            floor_q   <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            obj_q     <= obj_d;
            car_q     <= car_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            assign_q  <= assign_d;
            floor_q   <= floor_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.obj          = obj_q;
    assign bus.assign_a     = assign_q[0];
    assign bus.assign_b     = assign_q[1];
    assign bus.assign_c     = assign_q[2];
    assign bus.assign_floor = floor_q;
    assign pending          = pending_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_call_dispatcher.sv
// tb_call_dispatcher: scoreboard bench for call_dispatcher.
// The stimulus pushes each expected grant (car, floor, duration) into a queue. A monitor pops
// one entry at every grant rising edge and checks the duration when the grant drops.
module tb_call_dispatcher;
    localparam int unsigned FLOORS  = 16;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [FLOORS-1:0] call_in;
    logic [FLOORS-1:0] pending;
    logic              busy;

    call_dispatcher_if bus ();

    call_dispatcher #(.FLOORS(FLOORS), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .call_in (call_in),
        .pending (pending),
        .busy    (busy),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Prioritizer model: table of car choices per floor, combinational from obj.
    logic [2:0] sel_map [16];
    assign {bus.sel_c, bus.sel_b, bus.sel_a} = sel_map[bus.obj];

    typedef struct {
        logic [2:0] car;
        logic [3:0] floor;
        int         len;     // expected cycles high; 0 = not checked
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Car responder settings.
    logic [2:0] ack_en;
    logic [2:0] stray;
    int         ack_dly [3];
    int         cnt [3];
    logic [2:0] r_asg;
    logic [2:0] r_ack;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [FLOORS-1:0] bitf(input int f);
        return FLOORS'(1) << f;
    endfunction

    function automatic logic any_asg();
        return bus.assign_a | bus.assign_b | bus.assign_c;
    endfunction

    task automatic push(input logic [2:0] car, input int fl, input int len);
        exp_t e;
        e.car   = car;
        e.floor = 4'(fl);
        e.len   = len;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [FLOORS-1:0] v);
        @(posedge clk); #1 call_in = v;
        @(posedge clk); #1 call_in = '0;
    endtask

    task automatic wait_rise(input int budget, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (!any_asg() && n < budget);
        chk({nm, "_rise"}, int'(any_asg()), 1);
    endtask

    task automatic wait_fall(input int budget, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end while (any_asg() && n < budget);
        chk({nm, "_fall"}, int'(any_asg()), 0);
    endtask

    task automatic drain(input int budget, input string nm);
        int n = 0;
        do begin @(negedge clk); n++; end
        while (!(exp_q.size() == 0 && pending == '0 && !busy) && n < budget);
        chk({nm, "_drain"}, exp_q.size(), 0);
    endtask

    // Car controllers: ack after ack_dly cycles of a grant when enabled; stray acks are forced.
    initial begin
        bus.ack_a = 1'b0;
        bus.ack_b = 1'b0;
        bus.ack_c = 1'b0;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        forever begin
            @(negedge clk);
            r_asg = {bus.assign_c, bus.assign_b, bus.assign_a};
            for (int k = 0; k < 3; k++) begin
                if (r_asg[k]) cnt[k]++; else cnt[k] = 0;
                r_ack[k] = ack_en[k] && r_asg[k] && (cnt[k] == ack_dly[k] + 1);
            end
            {bus.ack_c, bus.ack_b, bus.ack_a} = r_ack | stray;
        end
    end

    // Monitor: checks every grant against the scoreboard.
    logic [2:0] m_cur;
    logic [2:0] m_prev = 3'b000;
    int         m_len = 0;
    int         m_len_exp = 0;
    exp_t       m_e;

    always @(negedge clk) begin
        m_cur = {bus.assign_c, bus.assign_b, bus.assign_a};
        if (m_cur != 3'b000) chk("onehot", $countones(m_cur), 1);
        if (m_cur != 3'b000 && m_prev == 3'b000) begin
            chk("grant_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                m_e = exp_q.pop_front();
                chk("grant_car", int'(m_cur), int'(m_e.car));
                chk("grant_floor", int'(bus.assign_floor), int'(m_e.floor));
                m_len_exp = m_e.len;
            end else begin
                m_len_exp = 0;
            end
            m_len = 1;
        end else if (m_cur != 3'b000) begin
            m_len++;
        end else if (m_prev != 3'b000 && m_len_exp > 0) begin
            chk("grant_len", m_len, m_len_exp);
        end
        m_prev = m_cur;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        call_in = '0;
        ack_en  = 3'b111;
        stray   = 3'b000;
        for (int k = 0; k < 3; k++) ack_dly[k] = 0;
        for (int f = 0; f < 16; f++) sel_map[f] = 3'b000;

        // Reset state
        #12;
        chk("rst_pending", int'(pending), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_obj", int'(bus.obj), 0);
        chk("rst_floor", int'(bus.assign_floor), 0);
        chk("rst_assign", int'(any_asg()), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single call on floor 5 to car B, acked 2 cycles into the grant
        sel_map[5] = 3'b010;
        ack_dly[1] = 2;
        push(3'b010, 5, 3);
        @(posedge clk); #1 call_in = bitf(5);
        @(posedge clk); #1 call_in = '0;
        @(negedge clk);
        chk("t1_pending", int'(pending), 32);
        chk("t1_busy_idle", int'(busy), 0);
        chk("t1_no_assign1", int'(any_asg()), 0);
        @(negedge clk);
        chk("t1_obj", int'(bus.obj), 5);
        chk("t1_busy_eval", int'(busy), 1);
        chk("t1_no_assign2", int'(any_asg()), 0);
        @(negedge clk);
        chk("t1_assign_b", int'({bus.assign_c, bus.assign_b, bus.assign_a}), 2);
        chk("t1_floor", int'(bus.assign_floor), 5);
        wait_fall(20, "t1");
        chk("t1_cleared", int'(pending), 0);
        chk("t1_busy_done", int'(busy), 0);

        // ptr=10 with {2,9,14} pending: service 14, 2, 9
        sel_map[9]  = 3'b001;
        sel_map[2]  = 3'b010;
        sel_map[14] = 3'b010;
        ack_dly[0]  = 5;
        ack_dly[1]  = 0;
        push(3'b001, 9, 6);
        push(3'b010, 14, 1);
        push(3'b010, 2, 1);
        push(3'b001, 9, 6);
        press(bitf(9));
        wait_rise(10, "t2a");
        press(bitf(2) | bitf(14));
        wait_fall(20, "t2a");
        press(bitf(9));
        drain(200, "t2");

        // Pointer wrap: 15 then 0
        sel_map[15] = 3'b100;
        sel_map[0]  = 3'b100;
        ack_dly[2]  = 0;
        push(3'b100, 15, 1);
        push(3'b100, 0, 1);
        press(bitf(0) | bitf(15));
        drain(100, "t3");

        // Floor 7 with no car: skipped and kept, retried, later served by C
        ack_dly[0] = 0;
        press(bitf(7));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t4_no_grant", int'(any_asg()), 0);
        end
        chk("t4_pending7", int'(pending), 128);
        sel_map[9] = 3'b001;
        sel_map[6] = 3'b101;
        push(3'b001, 9, 1);
        push(3'b001, 6, 1);
        push(3'b100, 7, 1);
        press(bitf(9) | bitf(6));
        wait_rise(10, "t4");
        sel_map[7] = 3'b100;
        drain(200, "t4");

        // Timeout on car A with stray ack_b, then retry that is acked
        sel_map[3] = 3'b001;
        ack_en[0]  = 1'b0;
        stray      = 3'b010;
        push(3'b001, 3, TIMEOUT);
        push(3'b001, 3, 1);
        press(bitf(3));
        wait_rise(20, "t5");
        wait_fall(20, "t5");
        chk("t5_pending_kept", int'(pending), 8);
        ack_en[0] = 1'b1;
        stray     = 3'b000;
        drain(100, "t5");

        // Press on floor 4 in the same cycle as its ack is absorbed
        sel_map[4] = 3'b100;
        ack_dly[2] = 1;
        push(3'b100, 4, 2);
        press(bitf(4));
        wait_rise(10, "t6");
        press(bitf(4));
        @(negedge clk);
        chk("t6_absorbed", int'(pending), 0);
        chk("t6_dropped", int'(any_asg()), 0);
        drain(50, "t6");

        // Reset in the middle of a grant drops everything
        sel_map[11] = 3'b010;
        sel_map[12] = 3'b010;
        sel_map[13] = 3'b010;
        ack_en[1]   = 1'b0;
        push(3'b010, 11, 0);
        press(bitf(11) | bitf(12));
        wait_rise(10, "t7");
        #2 rst_n = 1'b0;
        #1;
        chk("t7_rst_assign", int'(any_asg()), 0);
        chk("t7_rst_pending", int'(pending), 0);
        chk("t7_rst_busy", int'(busy), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        ack_en[1]  = 1'b1;
        ack_dly[1] = 0;
        push(3'b010, 13, 1);
        press(bitf(13));
        drain(100, "t7");

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
